// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: command/condition encodings, FSM states and the data-processing decoder
package alu_ctrl_pkg;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_MUL = 4'b0111;
  typedef enum logic [3:0] {
    C_EQ, C_NE, C_CS, C_CC, C_MI, C_PL, C_VS, C_VC,
    C_HI, C_LS, C_GE, C_LT, C_GT, C_LE, C_AL, C_NV
  } cond_e;
  typedef enum logic [1:0] {IDLE, EXEC, MULW} state_e;
  typedef struct packed {
    logic [3:0] alu_control;
    logic [1:0] flag_w;
    logic       no_write;
  } ctrl_t;
  function automatic ctrl_t decode(input logic alu_op, input logic [4:0] funct);
    logic [3:0] cmd;
    logic       s;
    logic       arith;
    logic       logic_op;
    cmd = funct[4:1];
    s = funct[0];
    arith = (cmd == CMD_ADD) || (cmd == CMD_SUB);
    logic_op = (cmd == CMD_AND) || (cmd == CMD_ORR) || (cmd == CMD_EOR);
    decode.alu_control = !alu_op ? CMD_ADD : (cmd == CMD_CMP) ? CMD_SUB : cmd;
    decode.flag_w = !alu_op ? 2'b00 :
                    ((cmd == CMD_CMP) || (s && arith)) ? 2'b11 :
                    (s && logic_op) ? 2'b10 : 2'b00;
    decode.no_write = alu_op && (cmd == CMD_CMP);
  endfunction
endpackage

// File: rtl/alu_ctrl_unit_cond_check.sv
// cond_check: ARM condition-code evaluation against an NZCV snapshot
module cond_check
  import alu_ctrl_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_nzcv,
  output logic       o_pass
);
  logic w_n, w_z, w_c, w_v;
  assign {w_n, w_z, w_c, w_v} = i_nzcv;
  always_comb begin
    case (cond_e'(i_cond))
      C_EQ:    o_pass = w_z;
      C_NE:    o_pass = !w_z;
      C_CS:    o_pass = w_c;
      C_CC:    o_pass = !w_c;
      C_MI:    o_pass = w_n;
      C_PL:    o_pass = !w_n;
      C_VS:    o_pass = w_v;
      C_VC:    o_pass = !w_v;
      C_HI:    o_pass = w_c && !w_z;
      C_LS:    o_pass = !w_c || w_z;
      C_GE:    o_pass = w_n == w_v;
      C_LT:    o_pass = w_n != w_v;
      C_GT:    o_pass = !w_z && (w_n == w_v);
      C_LE:    o_pass = w_z || (w_n != w_v);
      default: o_pass = 1'b1;
    endcase
  end
endmodule

// File: rtl/alu_ctrl_unit.sv
// alu_ctrl_unit: registered ALU decode with condition check, NZCV register and multi-cycle MUL stall
module alu_ctrl_unit
  import alu_ctrl_pkg::*;
#(
  parameter int         MUL_LAT = 4,
  parameter logic [3:0] MUL_CMD = CMD_MUL
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       alu_op,
  input  logic [4:0] funct,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  output logic       out_valid,
  output logic [3:0] alu_control,
  output logic [1:0] flag_w,
  output logic       no_write,
  output logic       cond_ex,
  output logic       busy,
  output logic [3:0] flags
);
  if (MUL_LAT < 2 || MUL_LAT > 15) begin : g_bad_lat
    $error("alu_ctrl_unit: MUL_LAT must be within 2..15");
  end
  localparam logic [3:0] CNT_LOAD = 4'(MUL_LAT - 2);
  state_e     r_state, w_next;
  logic [3:0] r_cnt, w_cnt;
  logic [3:0] r_flags, w_nzcv;
  logic [3:0] r_alu_control;
  logic [1:0] r_flag_w;
  logic       r_no_write, r_cond_ex;
  logic       w_accept, w_is_mul, w_pass;
  ctrl_t      w_dec;
  assign w_accept = in_valid && (r_state != MULW);
  assign w_is_mul = alu_op && (funct[4:1] == MUL_CMD);
  assign w_dec = decode(alu_op, funct);
  // flags as they stand after the executing op retires, so a back-to-back accept sees them
  assign w_nzcv = {
    (r_state == EXEC && r_flag_w[1]) ? alu_flags[3:2] : r_flags[3:2],
    (r_state == EXEC && r_flag_w[0]) ? alu_flags[1:0] : r_flags[1:0]
  };
  cond_check u_cond_check (
    .i_cond(cond),
    .i_nzcv(w_nzcv),
    .o_pass(w_pass)
  );
  always_comb begin
    in_ready = r_state != MULW;
    out_valid = r_state == EXEC;
    busy = r_state == MULW;
    w_next = (r_state == MULW) ? ((r_cnt == 4'd0) ? EXEC : MULW) :
             !w_accept ? IDLE : w_is_mul ? MULW : EXEC;
    w_cnt = (r_state == MULW) ? ((r_cnt == 4'd0) ? 4'd0 : r_cnt - 4'd1) :
            (w_accept && w_is_mul) ? CNT_LOAD : 4'd0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt <= 4'd0;
      r_flags <= 4'd0;
      r_alu_control <= 4'd0;
      r_flag_w <= 2'd0;
      r_no_write <= 1'b0;
      r_cond_ex <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt <= w_cnt;
      r_flags <= w_nzcv;
      if (w_accept) begin
        r_alu_control <= w_dec.alu_control;
        r_flag_w <= w_pass ? w_dec.flag_w : 2'b00;
        r_no_write <= w_pass ? w_dec.no_write : 1'b1;
        r_cond_ex <= w_pass;
      end
    end
  end
  assign alu_control = r_alu_control;
  assign flag_w = r_flag_w;
  assign no_write = r_no_write;
  assign cond_ex = r_cond_ex;
  assign flags = r_flags;
endmodule

// File: tb/tb_alu_ctrl_unit.sv
// tb_alu_ctrl_unit: directed scenarios plus randomized traffic checked against a cycle-stamped reference model
module tb_alu_ctrl_unit;
  localparam int LAT = 4;
  localparam logic [3:0] MULC = 4'b0111;
  logic       clk, rst_n, in_valid, in_ready, alu_op;
  logic [4:0] funct;
  logic [3:0] cond, alu_flags, alu_control, flags;
  logic       out_valid, no_write, cond_ex, busy;
  logic [1:0] flag_w;
  int n_err = 0;
  int n_chk = 0;
  int cyc = 0;
  int acc_cyc = -100;
  int out_cyc = -100;
  logic       m_mul = 1'b0;
  logic [3:0] m_flags = 4'd0;
  logic [3:0] m_ctl = 4'd0;
  logic [1:0] m_fw = 2'd0;
  logic       m_nw = 1'b0;
  logic       m_ce = 1'b0;
  alu_ctrl_unit #(.MUL_LAT(LAT), .MUL_CMD(MULC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct), .cond(cond), .alu_flags(alu_flags),
    .out_valid(out_valid), .alu_control(alu_control), .flag_w(flag_w),
    .no_write(no_write), .cond_ex(cond_ex), .busy(busy), .flags(flags)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask
  function automatic logic ref_pass(input logic [3:0] cd, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cd)
      4'd0: return z;
      4'd1: return !z;
      4'd2: return c;
      4'd3: return !c;
      4'd4: return n;
      4'd5: return !n;
      4'd6: return v;
      4'd7: return !v;
      4'd8: return c && !z;
      4'd9: return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction
  function automatic logic [6:0] ref_dec(input logic aop, input logic [4:0] fn);
    logic [3:0] c;
    logic s;
    c = fn[4:1];
    s = fn[0];
    if (!aop) return {4'b0100, 2'b00, 1'b0};
    if (c == 4'b1010) return {4'b0010, 2'b11, 1'b1};
    if (s && (c == 4'b0100 || c == 4'b0010)) return {c, 2'b11, 1'b0};
    if (s && (c == 4'b0000 || c == 4'b1100 || c == 4'b0001)) return {c, 2'b10, 1'b0};
    return {c, 2'b00, 1'b0};
  endfunction
  task automatic step(input logic iv, input logic aop, input logic [4:0] fn,
                      input logic [3:0] cd, input logic [3:0] af);
    logic ov, bz, p;
    logic [6:0] d;
    ov = (cyc == out_cyc);
    bz = m_mul && cyc > acc_cyc && cyc < out_cyc;
    chk("out_valid", out_valid, ov);
    chk("busy", busy, bz);
    chk("in_ready", in_ready, !bz);
    chk("alu_control", alu_control, m_ctl);
    chk("flag_w", flag_w, m_fw);
    chk("no_write", no_write, m_nw);
    chk("cond_ex", cond_ex, m_ce);
    chk("flags", flags, m_flags);
    in_valid = iv;
    alu_op = aop;
    funct = fn;
    cond = cd;
    alu_flags = af;
    if (ov) begin
      if (m_fw[1]) m_flags[3:2] = af[3:2];
      if (m_fw[0]) m_flags[1:0] = af[1:0];
    end
    if (iv && !bz) begin
      d = ref_dec(aop, fn);
      p = ref_pass(cd, m_flags);
      m_ctl = d[6:3];
      m_fw = p ? d[2:1] : 2'b00;
      m_nw = p ? d[0] : 1'b1;
      m_ce = p;
      m_mul = aop && (fn[4:1] == MULC);
      acc_cyc = cyc;
      out_cyc = cyc + (m_mul ? LAT : 1);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic do_reset;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_flags", flags, 0);
    chk("rst_alu_control", alu_control, 0);
    chk("rst_flag_w", flag_w, 0);
    chk("rst_no_write", no_write, 0);
    chk("rst_cond_ex", cond_ex, 0);
    m_flags = 4'd0;
    m_ctl = 4'd0;
    m_fw = 2'd0;
    m_nw = 1'b0;
    m_ce = 1'b0;
    m_mul = 1'b0;
    acc_cyc = -100;
    out_cyc = -100;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    logic [3:0] cmds [8];
    logic [3:0] c;
    cmds = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1100, 4'b1010, 4'b0111, 4'b1111};
    in_valid = 1'b0;
    alu_op = 1'b0;
    funct = 5'd0;
    cond = 4'd0;
    alu_flags = 4'd0;
    do_reset;
    step(1, 1, 5'b01001, 4'b1110, 4'h0);
    chk("r37_out_valid", out_valid, 1);
    chk("r37_alu_control", alu_control, 4'b0100);
    chk("r37_flag_w", flag_w, 2'b11);
    step(0, 0, 5'd0, 4'd0, 4'b0110);
    chk("r37_flags", flags, 4'b0110);
    step(1, 1, 5'b00101, 4'b1110, 4'h0);
    step(0, 0, 5'd0, 4'd0, 4'b0100);
    step(1, 1, 5'b10100, 4'b0001, 4'h0);
    chk("r38_cond_ex", cond_ex, 0);
    chk("r38_flag_w", flag_w, 2'b00);
    chk("r38_no_write", no_write, 1);
    step(0, 0, 5'd0, 4'd0, 4'b1011);
    chk("r38_flags", flags, 4'b0100);
    step(1, 1, 5'b01110, 4'b1110, 4'h0);
    for (int i = 0; i < LAT - 1; i++) begin
      chk("r39_busy", busy, 1);
      chk("r39_in_ready", in_ready, 0);
      chk("r39_out_valid", out_valid, 0);
      step(1, 1, 5'b00101, 4'b1110, 4'h0);
    end
    chk("r39_out_valid_late", out_valid, 1);
    chk("r39_alu_control", alu_control, MULC);
    step(0, 0, 5'd0, 4'd0, 4'h0);
    do_reset;
    step(1, 1, 5'b00101, 4'b1110, 4'h0);
    step(1, 1, 5'b01000, 4'b0000, 4'b0100);
    chk("r40_cond_ex", cond_ex, 1);
    step(0, 0, 5'd0, 4'd0, 4'h0);
    step(1, 1, 5'b01110, 4'b1110, 4'h0);
    step(0, 0, 5'd0, 4'd0, 4'h0);
    chk("r41_busy_before", busy, 1);
    do_reset;
    step(1, 0, 5'b11111, 4'b1110, 4'hF);
    chk("r42_alu_control", alu_control, 4'b0100);
    chk("r42_flag_w", flag_w, 2'b00);
    chk("r42_no_write", no_write, 0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset;
      c = ($urandom_range(0, 3) == 0) ? 4'($urandom) : cmds[$urandom_range(0, 7)];
      step($urandom_range(0, 9) < 7, $urandom_range(0, 7) != 0, {c, 1'($urandom)},
           ($urandom_range(0, 2) == 0) ? 4'b1110 : 4'($urandom), 4'($urandom));
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
